uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit datapath that sits directly downstream of the transmit-control set/reset flop.
- The flop's Q output ("doit") enables this block's bit-time and bit counters.
- This block serializes one loaded character onto the TX line as a fixed 11-bit frame.
- At the end of the frame it emits a one-cycle "done" pulse that drives the flop's r input and ends the transmission.

Parameters:
- BAUD_W, 19, width of the bit-time terminal count input baud_k.
- FRAME_BITS, 11, bits per frame including start and stop/fill bits. Fixed; no other value supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- doit  input  1  transmit enable from the set/reset flop. 1 = frame in progress.
- load  input  1  one-cycle write strobe; captures data into the shift register.
- data  input  8  character to send; d[0] is sent first.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits (d[7] ignored).
- pen  input  1  parity enable.
- ohel  input  1  parity select: 1 = odd, 0 = even.
- baud_k  input  BAUD_W  clocks per bit. A value of 0 is treated as 1.
- tx  output  1  serial line; idle high.
- done  output  1  one-cycle pulse at the end of the frame.
- btu  output  1  one-cycle bit-time-up strobe, for debug and status use.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - shift register = all 1s, so tx = 1.
  - baud counter = 0, bit counter = 0, done = 0, btu = 0.
- Frame assembly on load, accepted only when doit = 0. Load while doit = 1 is ignored and the frame in progress is unaffected.
- The 11-bit shift register sr[10:0] loads {b10, b9, d[6:0], 0, 1}, where sr[0] = 1 is the idle bit currently on the line and sr[1] = 0 is the start bit. The effective frame, LSB first after the idle bit, is:
  - eight=1, pen=1: start, d0..d7, parity, stop.
  - eight=1, pen=0: start, d0..d7, stop, stop.
  - eight=0, pen=1: start, d0..d6, parity, stop, stop.
  - eight=0, pen=0: start, d0..d6, stop, stop, stop.
- Parity = XOR of the data bits actually sent, XOR ohel.
- tx = sr[0], registered; no combinational path from inputs to tx.
- Baud counter:
  - Increments every cycle while doit = 1 and done = 0; otherwise held at 0.
  - When count == max(baud_k,1) - 1: btu = 1 for that cycle and the counter wraps to 0.
- Shifting: on each btu, sr shifts right by one with a 1 filled into sr[10], and the bit counter increments.
- Timing from the first cycle with doit = 1:
  - tx presents the start bit after the first btu, i.e. baud_k cycles after doit rises.
  - Each subsequent bit is held for exactly baud_k cycles.
- Done:
  - On the btu that takes the bit counter from 10 to 11: the bit counter clears to 0, and done is registered high for exactly one cycle.
  - In the cycle done = 1 the baud counter is held at 0, so no spurious btu occurs while doit falls.
  - After that btu, sr is all 1s and tx returns to idle 1.
- doit dropping mid-frame (flop cleared externally): counters clear to 0 in the next cycle; sr is forced to all 1s; tx = 1; no done pulse.
- A load and doit rising in the same cycle is legal: the load is accepted because doit was 0 at the prior edge's sampling.
- btu and done are never asserted while doit = 0.

Test Plan:
- Reset: assert rst mid-frame with baud_k = 4 -> tx = 1, done = 0, btu = 0 asynchronously; no btu after release while doit = 0.
- Baseline frame: baud_k = 4, data = 0x55, eight = 1, pen = 1, ohel = 0, load, then doit = 1 -> tx sequence 0,1,0,1,0,1,0,1,0,0,1 with each bit 4 cycles; done pulses once 44 cycles after doit rises; tx = 1 afterwards.
- Seven-bit odd parity: data = 0x41, eight = 0, pen = 1, ohel = 1, baud_k = 3 -> bits 0,1,0,0,0,0,0,1,1,1,1 (parity = 1); done at cycle 33.
- No parity, eight = 0: data = 0x7F, baud_k = 2 -> start 0, seven 1s, three stop 1s; exactly 11 btu pulses; done width = 1 cycle.
- Load ignored while busy: issue load with data = 0x00 during the frame of 0x55 -> transmitted bits are unchanged.
- doit cleared mid-frame plus baud_k = 0: drop doit after bit 3 -> tx = 1 the next cycle, no done pulse, counters at 0. With baud_k = 0 -> btu every cycle and a full frame completes in 11 cycles.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// Handshake and line signals between the transmit-control flop side and the TX serializer.
interface uart_tx_engine_if #(
    parameter int BAUD_W = 19
);
    logic              doit;
    logic              load;
    logic [7:0]        data;
    logic              eight;
    logic              pen;
    logic              ohel;
    logic [BAUD_W-1:0] baud_k;
    logic              tx;
    logic              done;
    logic              btu;

    modport master (
        output doit, load, data, eight, pen, ohel, baud_k,
        input  tx, done, btu
    );

    modport slave (
        input  doit, load, data, eight, pen, ohel, baud_k,
        output tx, done, btu
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: shifts one loaded character out as a fixed 11-bit frame
// and pulses done at the end so the upstream set/reset flop can clear doit.
module uart_tx_engine #(
    parameter int BAUD_W     = 19,
    parameter int FRAME_BITS = 11
) (
    input logic              clk,
    input logic              rst,
    uart_tx_engine_if.slave  bus
);
    localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);

    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] sr_next;
    logic [FRAME_BITS-1:0] frame;
    logic [BAUD_W-1:0]     bc;
    logic [BAUD_W-1:0]     kmax;
    logic [3:0]            nb;
    logic                  doit_q;
    logic                  done_q;
    logic                  btu;
    logic                  load_ok;
    logic                  par;
    logic                  b9;
    logic                  b10;

    always_comb begin
        kmax = (bus.baud_k == '0) ? BAUD_ONE : bus.baud_k;
        // rst is in the gate so btu stays low throughout reset even when baud_k <= 1
        btu  = !rst && bus.doit && !done_q && (bc == kmax - BAUD_ONE);

        par = (^(bus.data & {bus.eight, 7'h7f})) ^ bus.ohel;
        b9  = 1'b1;
        b10 = 1'b1;
        case ({bus.eight, bus.pen})
            2'b11:   begin b9 = bus.data[7]; b10 = par;  end
            2'b10:   begin b9 = bus.data[7]; b10 = 1'b1; end
            2'b01:   begin b9 = par;         b10 = 1'b1; end
            default: begin b9 = 1'b1;        b10 = 1'b1; end
        endcase
        frame = {b10, b9, bus.data[6:0], 1'b0, 1'b1};

        // Acceptance uses doit as last sampled, so a load coinciding with doit rising still lands.
        // Load is applied before the shift so a btu in that same cycle (baud_k <= 1) is not lost.
        load_ok = bus.load && !doit_q;
        sr_next = sr;
        if (load_ok) begin
            sr_next = frame;
        end
        if (btu) begin
            sr_next = {1'b1, sr_next[FRAME_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '1;
            bc     <= '0;
            nb     <= '0;
            done_q <= 1'b0;
            doit_q <= 1'b0;
        end else begin
            doit_q <= bus.doit;

            if (doit_q && !bus.doit) begin
                sr <= '1;
            end else begin
                sr <= sr_next;
            end

            if (!bus.doit || done_q || btu) begin
                bc <= '0;
            end else begin
                bc <= bc + BAUD_ONE;
            end

            done_q <= 1'b0;
            if (!bus.doit) begin
                nb <= '0;
            end else if (btu) begin
                if (nb == 4'(FRAME_BITS - 1)) begin
                    nb     <= '0;
                    done_q <= 1'b1;
                end else begin
                    nb <= nb + 4'd1;
                end
            end
        end
    end

    assign bus.tx   = sr[0];
    assign bus.done = done_q;
    assign bus.btu  = btu;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: table-driven frames, randomized frames against a
// frame-level reference model, plus hand-written reset and doit-drop sequences.
module tb_uart_tx_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_tx_engine_if #(.BAUD_W(19)) bus ();

    uart_tx_engine #(.BAUD_W(19), .FRAME_BITS(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        eight;
        logic        pen;
        logic        ohel;
        int          k;
        logic        busy_load;
        logic        same_cycle;
        logic [10:0] exp_bits;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Frame as seen on the line, bit-time 0 first: start, data bits, optional parity, then ones.
    function automatic logic [10:0] model_bits(input logic [7:0] d, input logic e, input logic p,
                                               input logic o);
        logic [10:0] b;
        int nd;
        int ones;
        b    = '1;
        b[0] = 1'b0;
        nd   = e ? 8 : 7;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            b[1+i] = d[i];
            ones += int'(d[i]);
        end
        if (p) b[1+nd] = ((ones % 2) != 0) ^ o;
        return b;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        logic txr  [0:255];
        logic btur [0:255];
        logic doner[0:255];
        logic [10:0] got_bits;
        int kk, tt, nbtu, ndone, done_t, bad_btu, bad_idle;
        logic drop;
        kk   = (v.k == 0) ? 1 : v.k;
        tt   = 12 * kk + 4;
        drop = 1'b0;

        @(posedge clk); #1;
        bus.data   = v.data;
        bus.eight  = v.eight;
        bus.pen    = v.pen;
        bus.ohel   = v.ohel;
        bus.baud_k = 19'(v.k);
        bus.load   = 1'b1;
        if (v.same_cycle) begin
            bus.doit = 1'b1;
        end else begin
            @(posedge clk); #1;
            bus.load = 1'b0;
            bus.doit = 1'b1;
        end

        for (int t = 0; t < tt; t++) begin
            if (v.busy_load && t == 2 * kk + 1) begin
                bus.load = 1'b1;
                bus.data = 8'h00;
            end
            @(negedge clk);
            txr[t]   = bus.tx;
            btur[t]  = bus.btu;
            doner[t] = bus.done;
            if (bus.done) drop = 1'b1;
            @(posedge clk); #1;
            bus.load = 1'b0;
            if (drop) bus.doit = 1'b0;
        end
        bus.doit = 1'b0;

        for (int i = 0; i < 11; i++) got_bits[i] = txr[kk + i * kk + kk / 2];
        nbtu = 0; ndone = 0; done_t = -1; bad_btu = 0; bad_idle = 0;
        for (int t = 0; t < tt; t++) begin
            if (btur[t]) nbtu++;
            if (btur[t] != (((t + 1) % kk == 0) && (t < 11 * kk))) bad_btu++;
            if (doner[t]) begin ndone++; if (done_t < 0) done_t = t; end
            if (t < kk && txr[t] !== 1'b1) bad_idle++;
        end
        check({tag, "_bits"},     int'(got_bits), int'(v.exp_bits));
        check({tag, "_pre_idle"}, bad_idle, 0);
        check({tag, "_btu_cnt"},  nbtu, 11);
        check({tag, "_btu_pos"},  bad_btu, 0);
        check({tag, "_done_cnt"}, ndone, 1);
        check({tag, "_done_t"},   done_t, v.exp_done);
        check({tag, "_tx_idle"},  int'(txr[tt-1]), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int bad;
        bus.doit = 1'b0; bus.load = 1'b0; bus.data = '0;
        bus.eight = 1'b1; bus.pen = 1'b0; bus.ohel = 1'b0; bus.baud_k = 19'd4;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0, 11'b10010101010, 44};
        vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 11'b11110000010, 33};
        vecs[2] = '{8'h7F, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 11'b11111111110, 22};
        vecs[3] = '{8'h55, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 11'b10010101010, 44};
        vecs[4] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 11'b11101001010, 11};
        vecs[5] = '{8'h41, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b1, 11'b11110000010, 33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", int'(bus.tx), 1);
        check("rst_done", int'(bus.done), 0);
        check("rst_btu", int'(bus.btu), 0);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 10; i++) begin
            v.data       = 8'($urandom);
            v.eight      = 1'($urandom);
            v.pen        = 1'($urandom);
            v.ohel       = 1'($urandom);
            v.k          = int'($urandom_range(0, 6));
            v.busy_load  = 1'($urandom);
            v.same_cycle = 1'($urandom);
            v.exp_bits   = model_bits(v.data, v.eight, v.pen, v.ohel);
            v.exp_done   = 11 * ((v.k == 0) ? 1 : v.k);
            run_frame(v, $sformatf("rnd%0d", i));
        end

        // doit dropped during bit 3 of an all-zero character
        @(posedge clk); #1;
        bus.data = 8'h00; bus.eight = 1'b1; bus.pen = 1'b0; bus.baud_k = 19'd3; bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.doit = 1'b1;
        for (int t = 0; t < 13; t++) begin @(negedge clk); @(posedge clk); #1; end
        bus.doit = 1'b0;
        @(negedge clk);
        check("drop_pre_tx", int'(bus.tx), 0);
        bad = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.done !== 1'b0 || bus.btu !== 1'b0) bad++;
        end
        check("drop_quiet", bad, 0);
        v = vecs[1];
        run_frame(v, "after_drop");

        // asynchronous reset in the middle of a frame
        @(posedge clk); #1;
        bus.data = 8'h00; bus.eight = 1'b1; bus.pen = 1'b0; bus.baud_k = 19'd4; bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.doit = 1'b1;
        for (int t = 0; t < 11; t++) begin @(negedge clk); @(posedge clk); #1; end
        @(negedge clk);
        check("pre_rst_btu", int'(bus.btu), 1);
        check("pre_rst_tx", int'(bus.tx), 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", int'(bus.tx), 1);
        check("async_rst_done", int'(bus.done), 0);
        check("async_rst_btu", int'(bus.btu), 0);
        bus.doit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.btu !== 1'b0 || bus.tx !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        run_frame(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
